// File: rtl/seq_gen_1011.sv
// -----------------------------------------------------------------------------
// seq_gen_1011 -- serial pattern transmitter
//
// Emits PATTERN MSB-first on a 1-bit serial line, 'count' times per accepted
// start. Each repetition is followed by GAP idle zero bits so that a
// non-overlapping detector sees exactly one match per frame.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active-high, highest priority
//   start     in   run request, honoured only while idle
//   count     in   repetitions to send, latched when start is accepted
//   signal    out  serial data bit (registered)
//   frame     out  high while signal carries a pattern bit (registered)
//   busy      out  high from the cycle after an accepted start through DONE
//   done      out  one-cycle pulse after the final gap
//   sent_cnt  out  patterns completed since the last accepted start
// -----------------------------------------------------------------------------
module seq_gen_1011 #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               GAP     = 2,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             signal,
  output logic             frame,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_cnt
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  // The gap counter holds "gap cycles still to go after this one", so it only
  // has to reach GAP-1.
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic             signal_q, signal_d;
  logic             frame_q, frame_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] rem_dec;
  logic [IDX_W-1:0] idx_dec;

  assign rem_dec = rem_q - CNT_W'(1);
  assign idx_dec = idx_q - IDX_W'(1);

  // Output registers are loaded with the values belonging to the state being
  // entered, so every output lines up with state_q without any decode after
  // the flops.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    gap_d    = gap_q;
    sent_d   = sent_q;
    signal_d = 1'b0;
    frame_d  = 1'b0;
    busy_d   = 1'b1;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start && (count != '0)) begin
          state_d  = S_SEND;
          idx_d    = IDX_LAST;
          rem_d    = count;
          sent_d   = '0;
          signal_d = PATTERN[PAT_W-1];
          frame_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end

      S_SEND: begin
        if (idx_q != '0) begin
          idx_d    = idx_dec;
          signal_d = PATTERN[idx_dec];
          frame_d  = 1'b1;
        end else begin
          // Last bit of this repetition is on the line now.
          sent_d = sent_q + CNT_W'(1);
          rem_d  = rem_dec;
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LAST;
          end else if (rem_dec != '0) begin
            // No gap: next repetition starts back-to-back.
            idx_d    = IDX_LAST;
            signal_d = PATTERN[PAT_W-1];
            frame_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (rem_q != '0) begin
          state_d  = S_SEND;
          idx_d    = IDX_LAST;
          signal_d = PATTERN[PAT_W-1];
          frame_d  = 1'b1;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end

      S_DONE: begin
        // start is deliberately not looked at here; a new run needs IDLE.
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      rem_q    <= '0;
      gap_q    <= '0;
      sent_q   <= '0;
      signal_q <= 1'b0;
      frame_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      gap_q    <= gap_d;
      sent_q   <= sent_d;
      signal_q <= signal_d;
      frame_q  <= frame_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign signal   = signal_q;
  assign frame    = frame_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sent_cnt = sent_q;

endmodule

// File: tb/tb_seq_gen_1011.sv
// -----------------------------------------------------------------------------
// tb_seq_gen_1011 -- scoreboard bench for seq_gen_1011
//
// Two instances share the same stimulus: u_dut0 with the default 2-bit gap and
// u_dut1 with no gap. For every driven cycle the reference model works out,
// from the run's start cycle and count alone, what each output must look like
// in the following cycle and pushes it into a per-instance queue. A monitor
// pops those queues one cycle later and compares.
// -----------------------------------------------------------------------------
module tb_seq_gen_1011;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] count;

  logic             signal0, frame0, busy0, done0;
  logic [CNT_W-1:0] sent0;
  logic             signal1, frame1, busy1, done1;
  logic [CNT_W-1:0] sent1;

  seq_gen_1011 #(.PAT_W(4), .PATTERN(4'b1011), .GAP(2), .CNT_W(CNT_W)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .signal(signal0), .frame(frame0), .busy(busy0), .done(done0), .sent_cnt(sent0)
  );

  seq_gen_1011 #(.PAT_W(4), .PATTERN(4'b1011), .GAP(0), .CNT_W(CNT_W)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .signal(signal1), .frame(frame1), .busy(busy1), .done(done1), .sent_cnt(sent1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected word layout: {signal, frame, busy, done, sent_cnt[7:0]}
  logic [11:0] q0[$];
  logic [11:0] q1[$];

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Reference model state per instance: cycle index within the run (1-based,
  // 0 = no run), repetitions of the run, and the sent count shown when idle.
  int mk[2];
  int mn[2];
  int ms[2];
  int mgap[2];

  // Loopback detector bookkeeping (instance 0 only).
  logic       det_en = 1'b0;
  int         det_cnt = 0;
  int         det_last = -1;
  int         cyc = 0;
  logic [3:0] det_win = 4'b0;
  int         det_since = 0;

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s @%0t: got sig=%b frm=%b busy=%b done=%b sent=%0d, want sig=%b frm=%b busy=%b done=%b sent=%0d",
               name, $time, got[11], got[10], got[9], got[8], got[7:0],
               exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    total_cnt++;
    if (got != exp) begin
      bad_cnt++;
      $display("FAIL %s @%0t: got %0d want %0d", name, $time, got, exp);
    end
  endtask

  // Output of cycle k (1-based) of a run with n repetitions and the given gap:
  // frames of PAT_W pattern bits plus gap zeros, then a single done cycle.
  function automatic logic [11:0] run_out(input int gap, input int n, input int k);
    logic [3:0] pat;
    int fl, r, p;
    pat = 4'b1011;
    fl  = PAT_W + gap;
    if (k == n * fl + 1) return {1'b0, 1'b0, 1'b1, 1'b1, 8'(n)};
    r = (k - 1) / fl;
    p = (k - 1) % fl;
    if (p < PAT_W) return {pat[PAT_W-1-p], 1'b1, 1'b1, 1'b0, 8'(r)};
    return {1'b0, 1'b0, 1'b1, 1'b0, 8'(r + 1)};
  endfunction

  task automatic model_step(input int m, input logic s, input logic [7:0] c,
                            input logic r, output logic [11:0] e);
    int  tot;
    logic busy_now;
    tot      = mn[m] * (PAT_W + mgap[m]) + 1;
    busy_now = (mk[m] >= 1) && (mk[m] <= tot);
    if (r) begin
      mk[m] = 0;
      ms[m] = 0;
      e = 12'h000;
    end else if (busy_now) begin
      mk[m]++;
      if (mk[m] > tot) begin
        mk[m] = 0;
        ms[m] = mn[m];
        e = {4'b0000, 8'(ms[m])};
      end else begin
        e = run_out(mgap[m], mn[m], mk[m]);
      end
    end else if (s && (c != 8'd0)) begin
      mk[m] = 1;
      mn[m] = int'(c);
      e = run_out(mgap[m], mn[m], 1);
      $display("run: inst=%0d gap=%0d count=%0d accepted @%0t", m, mgap[m], c, $time);
    end else begin
      e = {4'b0000, 8'(ms[m])};
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic s, input logic [7:0] c, input logic r);
    logic [11:0] e0, e1;
    @(negedge clk);
    start = s;
    count = c;
    rst   = r;
    model_step(0, s, c, r, e0);
    model_step(1, s, c, r, e1);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0);
  endtask

  // Monitor: compare whatever the scoreboard holds for this cycle.
  always @(posedge clk) begin
    logic [11:0] e;
    #1;
    cyc++;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("gap2_outputs", {signal0, frame0, busy0, done0, sent0}, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("gap0_outputs", {signal1, frame1, busy1, done1, sent1}, e);
    end
    if (det_en) begin
      det_win = {det_win[2:0], signal0};
      det_since++;
      if (det_since >= PAT_W && det_win == 4'b1011) begin
        det_cnt++;
        if (det_last >= 0) chk_int("loopback_spacing", cyc - det_last, 6);
        det_last  = cyc;
        det_since = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    mgap[0] = 2;
    mgap[1] = 0;
    for (int m = 0; m < 2; m++) begin
      mk[m] = 0;
      mn[m] = 0;
      ms[m] = 0;
    end
    rst   = 1'b1;
    start = 1'b0;
    count = '0;

    // Reset, then a single frame.
    step(1'b0, 8'd0, 1'b1);
    step(1'b0, 8'd0, 1'b1);
    step(1'b1, 8'd1, 1'b0);
    idle(10);

    // Three frames.
    step(1'b1, 8'd3, 1'b0);
    idle(22);

    // Five frames with the loopback detector watching instance 0.
    det_cnt   = 0;
    det_last  = -1;
    det_since = 0;
    det_win   = 4'b0;
    det_en    = 1'b1;
    step(1'b1, 8'd5, 1'b0);
    idle(34);
    det_en = 1'b0;
    chk_int("loopback_matches", det_cnt, 5);

    // count=0 request is ignored.
    step(1'b1, 8'd0, 1'b0);
    idle(4);

    // count=2 run with stray start pulses and count changes while busy.
    step(1'b1, 8'd2, 1'b0);
    for (int i = 0; i < 14; i++) step(1'($urandom % 2), 8'($urandom), 1'b0);
    idle(20);

    // Reset during the third bit of frame 2 of a count=4 run.
    step(1'b1, 8'd4, 1'b0);
    idle(8);
    step(1'b0, 8'd0, 1'b1);
    idle(12);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom % 4 == 0), 8'($urandom_range(0, 6)), 1'($urandom % 60 == 0));
    end
    idle(40);

    @(negedge clk);
    chk_int("queue0_drained", q0.size(), 0);
    chk_int("queue1_drained", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/seq_gen_1011.md
Name: seq_gen_1011

Overview:
Serial pattern transmitter. It is the source side of the team's 1011 sequence-detector FSMs. On a start command it emits a fixed bit pattern (default 1011) MSB-first on a 1-bit serial line, a programmable number of times. Each repetition is followed by an idle gap of zeros so that a non-overlapping detector sees one clean match per frame. It is used as stimulus generator and loopback partner for the detector blocks.

Parameters:
PAT_W, 4, pattern length in bits (>=2)
PATTERN, 4'b1011, bit pattern, transmitted MSB (bit PAT_W-1) first
GAP, 2, number of idle 0 bits driven after each pattern (0 allowed)
CNT_W, 8, width of repetition count and sent counter

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request; sampled only in IDLE
count  in  CNT_W  repetitions to send; latched on accepted start
signal  out  1  serial output bit, registered
frame  out  1  high while signal carries a pattern bit, registered
busy  out  1  high from the cycle after an accepted start through the DONE cycle
done  out  1  one-cycle pulse after the last gap completes
sent_cnt  out  CNT_W  patterns completed since last accepted start

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. rst=1 at a rising edge forces state IDLE, signal=0, frame=0, busy=0, done=0, sent_cnt=0, internal bit index and remaining count = 0. rst has priority over all other inputs.
- All outputs are registered. Nothing combinational from inputs reaches outputs.
- States: IDLE, SEND, GAP, DONE.
- IDLE: signal=0, frame=0, busy=0.
  - start=1 and count!=0: latch count into rem, clear sent_cnt, go to SEND with bit index = PAT_W-1.
  - start=1 and count==0: ignored. Stay IDLE, no done.
- SEND: signal=PATTERN[idx], frame=1, busy=1. idx decrements each cycle.
  - On idx==0: sent_cnt += 1, rem -= 1.
  - Next state: GAP if GAP>0; otherwise SEND again (idx reloads to PAT_W-1) if rem after decrement != 0, else DONE.
- GAP: signal=0, frame=0, busy=1, for exactly GAP cycles (gap counter). Then SEND (idx = PAT_W-1) if rem != 0, else DONE.
- DONE: done=1 and busy=1 for exactly one cycle, signal=0. Then IDLE.
- Latency: first pattern bit appears on signal in the cycle immediately after the edge that samples start.
- Frame length: PAT_W+GAP cycles per repetition. Total busy cycles = count*(PAT_W+GAP)+1.
- start while busy (SEND/GAP/DONE) is ignored. count changes after acceptance have no effect.
- start asserted in the DONE cycle is ignored. A new start is accepted in IDLE the following cycle or later.
- sent_cnt wraps modulo 2^CNT_W; it cannot exceed count, so wrap is unreachable in normal use.
- rst mid-SEND or mid-GAP: truncates immediately. The next cycle is IDLE with signal=0 and no done pulse.

Test Plan:
- Single frame, defaults: rst 2 cycles, start=1 with count=1 for 1 cycle -> signal = 1,0,1,1 with frame=1 for cycles 1-4 after start, then 0,0 with frame=0, done=1 at cycle 7, busy low at cycle 8, sent_cnt=1.
- Three frames: count=3 -> signal stream 101100 101100 101100, done at cycle 19, sent_cnt steps 1,2,3 at the last bit of each frame.
- Loopback: connect signal to the existing 1011 non-overlapping Moore detector, count=5 -> detector out pulses exactly 5 times, one per frame, spaced 6 cycles apart.
- Ignored requests: start with count=0 -> busy stays 0, no done. Start pulses during an active count=2 run -> waveform identical to a clean count=2 run.
- Reset mid-operation: assert rst at the 3rd bit of frame 2 of count=4 -> next cycle signal=0, busy=0, sent_cnt=0, and no done ever.
- GAP=0 variant with count=2 -> signal 10111011 back-to-back, frame high 8 cycles, done at cycle 9.
